// File: rtl/audio_output_dac.sv
// Serial DAC transmitter: takes 32-bit stereo words over valid/ready and shifts them
// MSB first onto AUD_DACDAT, framed by the codec-mastered AUD_BCLK / AUD_DACLRCK.
module audio_output_dac #(
  parameter int WORD_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  Clk,
  input  logic                  reset,
  input  logic                  AUD_BCLK,
  input  logic                  AUD_DACLRCK,
  output logic                  AUD_DACDAT,
  input  logic [WORD_WIDTH-1:0] Send_Data,
  input  logic                  Send_Valid,
  output logic                  Send_Ready,
  output logic                  Send_Done,
  output logic                  Underrun
);

  localparam int CNT_W = $clog2(WORD_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    FRAME_START,
    SHIFT
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [SYNC_STAGES-1:0] r_bclkSync;
  logic [SYNC_STAGES-1:0] r_lrckSync;
  logic                   r_bclkPrev;
  logic                   r_lrckPrev;
  logic                   w_bclkFall;
  logic                   w_lrckRise;

  logic [WORD_WIDTH-1:0]  r_hold;
  logic                   r_holdFull;
  logic                   r_wordAvail;
  logic                   w_accept;

  logic [WORD_WIDTH-1:0]  r_shift;
  logic [CNT_W-1:0]       r_bitCnt;
  logic                   r_dacdat;
  logic                   r_done;
  logic                   r_underrun;

  logic                   w_load;
  logic                   w_shiftEn;
  logic                   w_finish;
  logic                   w_captureAvail;
  logic                   w_dacNext;

  // Codec clocks are only sampled; the extra "prev" flop turns them into edge strobes.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_bclkSync <= '0;
      r_lrckSync <= '0;
      r_bclkPrev <= 1'b0;
      r_lrckPrev <= 1'b0;
    end else begin
      r_bclkSync <= {r_bclkSync[SYNC_STAGES-2:0], AUD_BCLK};
      r_lrckSync <= {r_lrckSync[SYNC_STAGES-2:0], AUD_DACLRCK};
      r_bclkPrev <= r_bclkSync[SYNC_STAGES-1];
      r_lrckPrev <= r_lrckSync[SYNC_STAGES-1];
    end
  end

  assign w_bclkFall = r_bclkPrev & ~r_bclkSync[SYNC_STAGES-1];
  assign w_lrckRise = ~r_lrckPrev & r_lrckSync[SYNC_STAGES-1];

  assign Send_Ready = ~r_holdFull;
  assign w_accept   = Send_Valid & ~r_holdFull;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Word availability is sampled on the lrck_rise cycle so a same-cycle transfer waits a frame.
  always_comb begin
    w_nextState    = r_state;
    w_load         = 1'b0;
    w_shiftEn      = 1'b0;
    w_finish       = 1'b0;
    w_captureAvail = 1'b0;
    w_dacNext      = r_dacdat;
    case (r_state)
      IDLE: begin
        w_dacNext = 1'b0;
        if (w_lrckRise) begin
          w_captureAvail = 1'b1;
          w_nextState    = FRAME_START;
        end
      end
      FRAME_START: begin
        w_load      = 1'b1;
        w_dacNext   = r_wordAvail & r_hold[WORD_WIDTH-1];
        w_nextState = SHIFT;
      end
      SHIFT: begin
        if (w_lrckRise) begin
          w_captureAvail = 1'b1;
          w_nextState    = FRAME_START;
        end else if (w_bclkFall) begin
          if (r_bitCnt == '0) begin
            w_finish    = 1'b1;
            w_dacNext   = 1'b0;
            w_nextState = IDLE;
          end else begin
            w_shiftEn = 1'b1;
            w_dacNext = r_shift[WORD_WIDTH-2];
          end
        end
      end
      default: begin
        w_nextState = IDLE;
        w_dacNext   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_hold      <= '0;
      r_holdFull  <= 1'b0;
      r_wordAvail <= 1'b0;
    end else begin
      if (w_captureAvail) begin
        r_wordAvail <= r_holdFull;
      end
      if (w_accept) begin
        r_hold     <= Send_Data;
        r_holdFull <= 1'b1;
      end else if (w_load && r_wordAvail) begin
        r_holdFull <= 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_shift    <= '0;
      r_bitCnt   <= LAST_BIT;
      r_dacdat   <= 1'b0;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_dacdat   <= w_dacNext;
      r_done     <= w_finish;
      r_underrun <= w_load & ~r_wordAvail;
      if (w_load) begin
        r_shift  <= r_wordAvail ? r_hold : '0;
        r_bitCnt <= LAST_BIT;
      end else if (w_shiftEn) begin
        r_shift  <= r_shift << 1;
        r_bitCnt <= r_bitCnt - 1'b1;
      end
    end
  end

  assign AUD_DACDAT = r_dacdat;
  assign Send_Done  = r_done;
  assign Underrun   = r_underrun;

endmodule
